heartbeat_monitor: RTL and testbench
====================================

# heartbeat_monitor

Receive-side checker for the periodic one-cycle `beat` pulse produced by the heartbeat generator. It measures the interval between beat rising edges and locks once a run of consecutive intervals falls inside a tolerance window. It flags early, late and missing beats, and declares the link lost after repeated consecutive misses. It sits next to any block that consumes a heartbeat, for liveness indication and fault statistics, in the same clock domain as the generator.

## Interface
- `CNT_W`, 22: interval counter width; requires `EXP_PERIOD+TOL+2 < 2**CNT_W`
- `EXP_PERIOD`, 1048576: nominal beat interval in clk cycles; requires `EXP_PERIOD > TOL`
- `TOL`, 1024: allowed ± deviation in cycles
- `LOCK_COUNT`, 4: consecutive good intervals required to lock (≥1)
- `MISS_LIMIT`, 2: consecutive misses in LOCKED that force LOST (≥1)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `beat_in`  in  1  heartbeat, synchronous to clk, any pulse length
- `state`  out  2  00 ACQUIRE, 01 SYNC, 10 LOCKED, 11 LOST
- `alive`  out  1  high iff state==LOCKED
- `lost`  out  1  high iff state==LOST
- `err_pulse`  out  1  one-cycle pulse per detected fault in SYNC or LOCKED
- `miss_count`  out  8  faults detected in LOCKED, saturates at 255
- `last_period`  out  CNT_W  last measured interval

## Operation
- Edge detect: `edge = beat_in & ~beat_q`. `beat_q` resets to 1, so a `beat_in` held high through reset produces no edge.
- Counter `cnt`:
  - edge cycle: `cnt <= 1`
  - timeout cycle: `cnt <= TOL+2`, which places a virtual reference at the ideal beat time
  - otherwise: `cnt <= cnt+1`, saturating at all-ones
- At an edge, the interval equals `cnt`.
- Interval classes, applied only in SYNC and LOCKED:
  - good: `EXP_PERIOD-TOL ≤ cnt ≤ EXP_PERIOD+TOL`
  - early: `cnt < EXP_PERIOD-TOL`
  - late: `cnt > EXP_PERIOD+TOL`
- Timeout: no edge in a cycle where `cnt == EXP_PERIOD+TOL+1`, in SYNC or LOCKED.
- A late edge that coincides with the timeout point counts as a single late fault, not as a timeout.
- `last_period <= cnt` on every classified edge, whether good or bad. It is not updated on timeout, nor on the first edge in ACQUIRE or LOST.
- Internal counters: `good_cnt` counts consecutive good intervals in SYNC; `miss_run` counts consecutive faults in LOCKED.
- FSM transitions:
  - ACQUIRE: edge → SYNC, with `good_cnt=0` and `miss_run=0`. The edge becomes the reference; no timeout is checked in this state.
  - SYNC:
    - good interval: `good_cnt++`; at `LOCK_COUNT` → LOCKED
    - early or late: `err_pulse`, `good_cnt=0`, stay in SYNC
    - timeout: `err_pulse`, → ACQUIRE
  - LOCKED:
    - good interval: `miss_run=0`
    - early, late or timeout: `err_pulse`, `miss_count++` (saturating), `miss_run++`; at `MISS_LIMIT` → LOST
  - LOST: no checks. Edge → SYNC as from ACQUIRE.
- `miss_count` is cleared only by reset.

## Timing
- All outputs are registered. An edge or timeout decided in cycle N is reflected in `state`, `alive`, `lost`, `err_pulse`, `miss_count` and `last_period` in cycle N+1.
- A `beat_in` rising edge sampled at clk edge N is treated as the edge cycle N.
- `err_pulse` is high for exactly one cycle per fault. A single event never produces more than one fault.
- Reset values: `state=00`, `alive=0`, `lost=0`, `err_pulse=0`, `miss_count=0`, `last_period=0`, `cnt=0`, `good_cnt=0`, `miss_run=0`, `beat_q=1`.
- Reset mid-operation returns to ACQUIRE on the next cycle and discards any in-flight edge or timeout.
- Dead input while LOCKED: successive timeouts occur `EXP_PERIOD+TOL+1` cycles after the last edge, then every `EXP_PERIOD` cycles.

## Test plan
All scenarios use `CNT_W=8`, `EXP_PERIOD=16`, `TOL=2`, `LOCK_COUNT=4`, `MISS_LIMIT=2`.
- Reset with `beat_in` held high, then release -> all outputs 0, `state=00`, no edge detected until `beat_in` falls and rises again.
- Beats every 16 cycles -> `state=01` after the 1st edge; `state=10` and `alive=1` one cycle after the 5th edge; `last_period=16`; `err_pulse` never asserted.
- While LOCKED, intervals of 14 and 18 -> no error. Interval 13 -> one `err_pulse`, `miss_count=1`, `last_period=13`. Then interval 19 -> `err_pulse`, `miss_count=2`, `state=11`.
- While LOCKED, stop beats -> `err_pulse` at 19 cycles after the last edge and again at 35; `lost=1` after the second; `miss_count=2`. The next edge gives `state=01`.
- While SYNC after 2 good intervals, stop beats -> `err_pulse` 19 cycles after the last edge, `state=00`, `miss_count` unchanged.
- While LOCKED, drive 300 early beats (interval 5), interleaving good intervals to avoid LOST -> `miss_count` saturates at 255. Then assert reset mid-run -> outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor port bundle: beat input plus registered status outputs.
interface heartbeat_monitor_if #(
  parameter int CNT_W = 22
);
  logic             beat_in;
  logic [1:0]       state;
  logic             alive;
  logic             lost;
  logic             err_pulse;
  logic [7:0]       miss_count;
  logic [CNT_W-1:0] last_period;

  modport master (
    output beat_in,
    input  state, alive, lost, err_pulse, miss_count, last_period
  );

  modport slave (
    input  beat_in,
    output state, alive, lost, err_pulse, miss_count, last_period
  );
endinterface

// File: rtl/heartbeat_monitor.sv
// Heartbeat receive checker: measures beat-to-beat interval, locks on a run of
// good intervals, and flags early/late/missing beats with loss detection.
module heartbeat_monitor #(
  parameter int CNT_W      = 22,
  parameter int EXP_PERIOD = 1048576,
  parameter int TOL        = 1024,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  heartbeat_monitor_if.slave  hb
);

  typedef enum logic [1:0] {
    ST_ACQ  = 2'b00,
    ST_SYNC = 2'b01,
    ST_LOCK = 2'b10,
    ST_LOST = 2'b11
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [CNT_W-1:0] LO_B   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_B   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TO_PT  = CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0] VREF   = CNT_W'(TOL + 2);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [GW-1:0]    LOCK_M1 = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0]    MISS_M1 = MW'(MISS_LIMIT - 1);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  state_t           r_state;
  logic             r_beat_q;
  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_good_cnt;
  logic [MW-1:0]    r_miss_run;
  logic             r_alive;
  logic             r_lost;
  logic             r_err;
  logic [7:0]       r_miss_count;
  logic [CNT_W-1:0] r_last_period;

  state_t           w_state_nxt;
  logic             w_edge;
  logic             w_checking;
  logic             w_timeout;
  logic             w_good;
  logic             w_fault_sync;
  logic             w_fault_lock;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [GW-1:0]    w_good_nxt;
  logic [MW-1:0]    w_miss_run_nxt;
  logic             w_err_nxt;
  logic [7:0]       w_miss_count_nxt;
  logic [CNT_W-1:0] w_last_period_nxt;

  assign w_edge       = hb.beat_in & ~r_beat_q;
  assign w_checking   = (r_state == ST_SYNC) || (r_state == ST_LOCK);
  // An edge landing exactly on the timeout point is classified as late only.
  assign w_timeout    = w_checking && !w_edge && (r_cnt == TO_PT);
  assign w_good       = (r_cnt >= LO_B) && (r_cnt <= HI_B);
  assign w_fault_sync = (r_state == ST_SYNC) && ((w_edge && !w_good) || w_timeout);
  assign w_fault_lock = (r_state == ST_LOCK) && ((w_edge && !w_good) || w_timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ACQ;
      r_beat_q      <= 1'b1;
      r_cnt         <= '0;
      r_good_cnt    <= '0;
      r_miss_run    <= '0;
      r_alive       <= 1'b0;
      r_lost        <= 1'b0;
      r_err         <= 1'b0;
      r_miss_count  <= '0;
      r_last_period <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_beat_q      <= hb.beat_in;
      r_cnt         <= w_cnt_nxt;
      r_good_cnt    <= w_good_nxt;
      r_miss_run    <= w_miss_run_nxt;
      r_alive       <= (w_state_nxt == ST_LOCK);
      r_lost        <= (w_state_nxt == ST_LOST);
      r_err         <= w_err_nxt;
      r_miss_count  <= w_miss_count_nxt;
      r_last_period <= w_last_period_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACQ, ST_LOST: begin
        if (w_edge) w_state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (w_edge && w_good && (r_good_cnt == LOCK_M1)) w_state_nxt = ST_LOCK;
        else if (w_timeout)                              w_state_nxt = ST_ACQ;
      end
      ST_LOCK: begin
        if (w_fault_lock && (r_miss_run == MISS_M1)) w_state_nxt = ST_LOST;
      end
      default: w_state_nxt = ST_ACQ;
    endcase
  end

  always_comb begin
    w_good_nxt        = r_good_cnt;
    w_miss_run_nxt    = r_miss_run;
    w_err_nxt         = w_fault_sync || w_fault_lock;
    w_miss_count_nxt  = w_fault_lock ? sat_inc8(r_miss_count) : r_miss_count;
    w_last_period_nxt = (w_checking && w_edge) ? r_cnt : r_last_period;

    // Timeout re-anchors the count at the ideal beat time, not at the timeout.
    if (w_edge)         w_cnt_nxt = ONE;
    else if (w_timeout) w_cnt_nxt = VREF;
    else                w_cnt_nxt = sat_inc_cnt(r_cnt);

    case (r_state)
      ST_ACQ, ST_LOST: begin
        if (w_edge) begin
          w_good_nxt     = '0;
          w_miss_run_nxt = '0;
        end
      end
      ST_SYNC: begin
        if (w_edge) w_good_nxt = w_good ? r_good_cnt + 1'b1 : '0;
      end
      ST_LOCK: begin
        if (w_fault_lock)          w_miss_run_nxt = r_miss_run + 1'b1;
        else if (w_edge && w_good) w_miss_run_nxt = '0;
      end
      default: ;
    endcase
  end

  assign hb.state       = r_state;
  assign hb.alive       = r_alive;
  assign hb.lost        = r_lost;
  assign hb.err_pulse   = r_err;
  assign hb.miss_count  = r_miss_count;
  assign hb.last_period = r_last_period;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scoreboard bench for heartbeat_monitor: a timestamp-based reference model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_heartbeat_monitor;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 16;
  localparam int TOL        = 2;
  localparam int LOCK_COUNT = 4;
  localparam int MISS_LIMIT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  heartbeat_monitor_if #(.CNT_W(CNT_W)) hb ();

  heartbeat_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL),
    .LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hb(hb)
  );

  typedef struct packed {
    logic [1:0]       st;
    logic             alive;
    logic             lost;
    logic             err;
    logic [7:0]       mc;
    logic [CNT_W-1:0] lp;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // Reference model: intervals come from cycle timestamps rather than a counter.
  int m_st, m_ref, m_good, m_run, m_mc, m_lp, m_cyc;
  bit m_prev, m_err;

  initial begin
    m_st = 0; m_ref = 0; m_good = 0; m_run = 0; m_mc = 0; m_lp = 0;
    m_cyc = 0; m_prev = 1'b1; m_err = 1'b0;
  end

  task automatic model_step(input bit r, input bit b);
    bit   edge_s, fault, in_win;
    int   iv;
    exp_t e;
    if (r) begin
      m_st = 0; m_good = 0; m_run = 0; m_mc = 0; m_lp = 0;
      m_prev = 1'b1; m_err = 1'b0; m_ref = m_cyc;
    end else begin
      edge_s = b && !m_prev;
      m_prev = b;
      m_err  = 1'b0;
      fault  = 1'b0;
      iv     = m_cyc - m_ref;
      in_win = (iv >= EXP_PERIOD - TOL) && (iv <= EXP_PERIOD + TOL);
      case (m_st)
        0, 3: if (edge_s) begin
          m_st = 1; m_ref = m_cyc; m_good = 0; m_run = 0;
        end
        1: begin
          if (edge_s) begin
            m_lp = iv; m_ref = m_cyc;
            if (in_win) begin
              m_good++;
              if (m_good == LOCK_COUNT) m_st = 2;
            end else begin
              m_err = 1'b1; m_good = 0;
            end
          end else if (iv == EXP_PERIOD + TOL + 1) begin
            m_err = 1'b1; m_st = 0;
          end
        end
        default: begin
          if (edge_s) begin
            m_lp = iv; m_ref = m_cyc;
            if (in_win) m_run = 0;
            else        fault = 1'b1;
          end else if (iv == EXP_PERIOD + TOL + 1) begin
            fault = 1'b1; m_ref = m_ref + EXP_PERIOD;
          end
          if (fault) begin
            m_err = 1'b1;
            if (m_mc < 255) m_mc++;
            m_run++;
            if (m_run == MISS_LIMIT) m_st = 3;
          end
        end
      endcase
    end
    m_cyc++;
    e.st    = 2'(m_st);
    e.alive = (m_st == 2);
    e.lost  = (m_st == 3);
    e.err   = m_err;
    e.mc    = 8'(m_mc);
    e.lp    = CNT_W'(m_lp);
    q.push_back(e);
  endtask

  task automatic apply(input bit r, input bit b);
    reset = r;
    hb.beat_in = b;
    model_step(r, b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0);
  endtask

  // One pulse of random width, padded so the next call's edge is iv cycles later.
  task automatic pulse_iv(input int iv);
    int len;
    len = $urandom_range(1, (iv - 1 < 3) ? iv - 1 : 3);
    for (int i = 0; i < iv; i++) apply(1'b0, i < len);
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (!done) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard-empty at t=%0t: no expected entry queued", $time);
        end
      end else begin
        e = q.pop_front();
        got.st    = hb.state;
        got.alive = hb.alive;
        got.lost  = hb.lost;
        got.err   = hb.err_pulse;
        got.mc    = hb.miss_count;
        got.lp    = hb.last_period;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs at t=%0t: got st=%b alive=%b lost=%b err=%b mc=%0d lp=%0d, want st=%b alive=%b lost=%b err=%b mc=%0d lp=%0d",
                   $time, got.st, got.alive, got.lost, got.err, got.mc, got.lp,
                   e.st, e.alive, e.lost, e.err, e.mc, e.lp);
        end
      end
    end
  end

  initial begin : stimulus
    int k;
    reset = 1'b1;
    hb.beat_in = 1'b1;
    // Reset with beat held high; release while still high, then fall.
    repeat (3) apply(1'b1, 1'b1);
    repeat (5) apply(1'b0, 1'b1);
    idle(4);
    // Nominal beats until locked.
    repeat (7) pulse_iv(16);
    // Tolerance edges, then early and late faults into LOST.
    pulse_iv(14); pulse_iv(18); pulse_iv(13); pulse_iv(19); pulse_iv(16);
    // Relock, then dead input: two timeouts into LOST, then recover to SYNC.
    repeat (6) pulse_iv(16);
    idle(40);
    // In SYNC with two good intervals, input dies: back to ACQUIRE.
    repeat (3) pulse_iv(16);
    idle(25);
    // Lock, then enough early beats to saturate miss_count.
    repeat (6) pulse_iv(16);
    repeat (300) begin
      pulse_iv(5);
      pulse_iv(16);
    end
    // Reset mid-run, coincident with a rising edge.
    idle(3);
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b0);
    idle(3);
    // Randomized intervals, dropouts and resets.
    repeat (250) begin
      k = $urandom_range(0, 19);
      if (k == 0)      idle($urandom_range(20, 45));
      else if (k == 1) apply(1'b1, 1'($urandom_range(0, 1)));
      else if (k < 10) pulse_iv($urandom_range(14, 18));
      else             pulse_iv($urandom_range(4, 22));
    end
    idle(4);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
